// File: rtl/alu_mb_ctrl_if.sv
// Command/result handshake bundle for the multi-byte ALU controller.
// The master drives commands and result acceptance; the slave is the controller.
interface alu_mb_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [1:0]  cmd_len;
    logic        cmd_ci;
    logic        cmd_bcd;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_co;
    logic        res_v;
    logic        res_n;
    logic        res_z;
    logic        res_err;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_ci, cmd_bcd, cmd_a, cmd_b, res_ready,
        input  cmd_ready, res_valid, res_data, res_co, res_v, res_n, res_z, res_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_ci, cmd_bcd, cmd_a, cmd_b, res_ready,
        output cmd_ready, res_valid, res_data, res_co, res_v, res_n, res_z, res_err
    );
endinterface

// File: rtl/alu_mb_ctrl.sv
// Sequences a 1..4 byte operation through an 8-bit registered ALU, chaining
// the carry byte to byte and assembling the 32-bit result with merged flags.
module alu_mb_ctrl (
    input  logic             clk,
    input  logic             rst_n,
    alu_mb_ctrl_if.slave     bus,
    output logic [3:0]       alu_op,
    output logic [7:0]       alu_ai,
    output logic [7:0]       alu_bi,
    output logic             alu_ci,
    output logic             alu_bcd,
    output logic             alu_rdy,
    output logic             alu_right,
    input  logic [7:0]       alu_out,
    input  logic             alu_co,
    input  logic             alu_v,
    input  logic             alu_z,
    input  logic             alu_n
);

    typedef enum logic [1:0] {IDLE, RUN, CAP, DONE} state_t;

    state_t      state, nxt;
    logic [3:0]  op_q;
    logic [1:0]  len_q;
    logic        ci_q;
    logic        bcd_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [1:0]  k_q;
    logic [31:0] data_q;
    logic        co_q, v_q, n_q, z_q, err_q, vld_q;
    logic        accept;
    logic        cmd_legal;
    logic [4:0]  cap_idx;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            4'b0011, 4'b0111, 4'b1011,
            4'b1100, 4'b1101, 4'b1110, 4'b1111: op_legal = 1'b1;
            default:                            op_legal = 1'b0;
        endcase
    endfunction

    assign bus.cmd_ready = rst_n && (state == IDLE);
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign cmd_legal     = op_legal(bus.cmd_op);

    // RUN captures the result of the byte issued in the previous cycle.
    assign cap_idx = (state == CAP) ? {len_q, 3'b000} : {k_q - 2'd1, 3'b000};

    assign alu_rdy   = (state == RUN);
    assign alu_op    = alu_rdy ? op_q : 4'd0;
    assign alu_ai    = alu_rdy ? a_q[{k_q, 3'b000} +: 8] : 8'd0;
    assign alu_bi    = alu_rdy ? b_q[{k_q, 3'b000} +: 8] : 8'd0;
    assign alu_bcd   = alu_rdy && bcd_q;
    assign alu_ci    = alu_rdy && ((k_q == 2'd0) ? ci_q : alu_co);
    assign alu_right = 1'b0;

    assign bus.res_valid = vld_q;
    assign bus.res_data  = data_q;
    assign bus.res_co    = co_q;
    assign bus.res_v     = v_q;
    assign bus.res_n     = n_q;
    assign bus.res_z     = z_q;
    assign bus.res_err   = err_q;

    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (accept) nxt = cmd_legal ? RUN : DONE;
            RUN:  if (k_q == len_q) nxt = CAP;
            CAP:  nxt = DONE;
            DONE: if (vld_q && bus.res_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q  <= bus.cmd_op;
            len_q <= bus.cmd_len;
            ci_q  <= bus.cmd_ci;
            bcd_q <= bus.cmd_bcd;
            a_q   <= bus.cmd_a;
            b_q   <= bus.cmd_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            k_q    <= 2'd0;
            data_q <= 32'd0;
            co_q   <= 1'b0;
            v_q    <= 1'b0;
            n_q    <= 1'b0;
            z_q    <= 1'b0;
            err_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            state <= nxt;
            case (state)
                IDLE: if (accept) begin
                    k_q    <= 2'd0;
                    data_q <= 32'd0;
                    co_q   <= 1'b0;
                    v_q    <= 1'b0;
                    n_q    <= 1'b0;
                    z_q    <= cmd_legal;
                    err_q  <= !cmd_legal;
                    vld_q  <= 1'b0;
                end
                RUN: begin
                    k_q <= k_q + 2'd1;
                    if (k_q != 2'd0) begin
                        data_q[cap_idx +: 8] <= alu_out;
                        z_q                  <= z_q && alu_z;
                    end
                end
                CAP: begin
                    data_q[cap_idx +: 8] <= alu_out;
                    z_q                  <= z_q && alu_z;
                    co_q                 <= alu_co;
                    v_q                  <= alu_v;
                    n_q                  <= alu_n;
                    vld_q                <= 1'b1;
                end
                DONE: begin
                    // Illegal ops arrive here straight from IDLE and post their result one cycle later.
                    if (!vld_q)
                        vld_q <= 1'b1;
                    else if (bus.res_ready)
                        vld_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
